// File: rtl/dadda_err_meter.sv
// dadda_err_meter: measures error statistics of an approximate 8x8 multiplier
// against the exact product over a run of N_SAMPLES pairs.
module dadda_err_meter #(
  parameter int N_SAMPLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] exact_p,
  input  logic [15:0] approx_p,
  output logic        busy,
  output logic        done,
  output logic [15:0] sample_cnt,
  output logic [15:0] err_cnt,
  output logic [15:0] max_ed,
  output logic [31:0] sum_ed
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam logic [15:0] LAST = 16'(N_SAMPLES - 1);
  state_t state;
  logic [15:0] ed, ed_q;
  logic nz_q, v_q, acc;
  assign ed = exact_p >= approx_p ? exact_p - approx_p : approx_p - exact_p;
  // in_ready is high only in RUN, so acceptance implies RUN
  assign acc = in_valid && in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sample_cnt <= '0;
      err_cnt    <= '0;
      max_ed     <= '0;
      sum_ed     <= '0;
      ed_q       <= '0;
      nz_q       <= 1'b0;
      v_q        <= 1'b0;
    end else begin
      v_q <= acc;
      if (acc) begin
        ed_q       <= ed;
        nz_q       <= |ed;
        sample_cnt <= sample_cnt + 16'd1;
      end
      if (v_q) begin
        err_cnt <= err_cnt + {15'd0, nz_q};
        sum_ed  <= sum_ed + {16'd0, ed_q};
        if (ed_q > max_ed) max_ed <= ed_q;
      end
      case (state)
        IDLE: if (start) begin
          state      <= RUN;
          in_ready   <= 1'b1;
          busy       <= 1'b1;
          sample_cnt <= '0;
          err_cnt    <= '0;
          max_ed     <= '0;
          sum_ed     <= '0;
        end
        RUN: if (acc && sample_cnt == LAST) begin
          state    <= DRAIN;
          in_ready <= 1'b0;
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dadda_err_meter.sv
// tb_dadda_err_meter: directed and randomised checks of dadda_err_meter
// instances with N_SAMPLES of 4, 1 and 256 against a queue-based model.
module tb_dadda_err_meter;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [2:0] start = '0, in_valid = '0, in_ready, busy, done;
  logic [15:0] exact_p [3], approx_p [3], sample_cnt [3], err_cnt [3], max_ed [3];
  logic [31:0] sum_ed [3];
  int total = 0, bad = 0;
  int dc [3] = '{0, 0, 0};
  logic [15:0] ev [$], av [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dadda_err_meter #(.N_SAMPLES(g == 0 ? 4 : g == 1 ? 1 : 256)) dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .in_valid(in_valid[g]),
      .in_ready(in_ready[g]), .exact_p(exact_p[g]), .approx_p(approx_p[g]),
      .busy(busy[g]), .done(done[g]), .sample_cnt(sample_cnt[g]),
      .err_cnt(err_cnt[g]), .max_ed(max_ed[g]), .sum_ed(sum_ed[g])
    );
  end

  always @(posedge clk) for (int i = 0; i < 3; i++) if (done[i]) dc[i]++;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(int d, logic [15:0] e, logic [15:0] a);
    exact_p[d] = e;
    approx_p[d] = a;
    in_valid[d] = 1'b1;
    @(negedge clk);
    in_valid[d] = 1'b0;
  endtask

  task automatic push(int d, logic [15:0] e, logic [15:0] a);
    ev.push_back(e);
    av.push_back(a);
    send(d, e, a);
  endtask

  task automatic begin_run(int d);
    ev.delete();
    av.delete();
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    chk("busy_run", 32'(busy[d]), 1);
    chk("ready_run", 32'(in_ready[d]), 1);
    chk("cleared", 32'(sample_cnt[d]) | 32'(err_cnt[d]) | 32'(max_ed[d]) | sum_ed[d], 0);
  endtask

  // called at the negedge right after the final accept
  task automatic finish(int d);
    int lat = 1, mx = 0, ec = 0, pdc;
    longint sm = 0;
    pdc = dc[d];
    for (int i = 0; i < ev.size(); i++) begin
      int df = int'(ev[i]) - int'(av[i]);
      if (df < 0) df = -df;
      if (df != 0) ec++;
      sm += df;
      if (df > mx) mx = df;
    end
    chk("ready_after_last", 32'(in_ready[d]), 0);
    while (!done[d] && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 2);
    chk("sample_cnt", 32'(sample_cnt[d]), ev.size());
    chk("err_cnt", 32'(err_cnt[d]), ec);
    chk("max_ed", 32'(max_ed[d]), mx);
    chk("sum_ed", sum_ed[d], 32'(sm));
    @(negedge clk);
    chk("done_pulse", 32'(done[d]), 0);
    chk("done_count", dc[d], pdc + 1);
    chk("busy_idle", 32'(busy[d]), 0);
    chk("hold_sum", sum_ed[d], 32'(sm));
  endtask

  initial begin
    int pdc, a, b, cnt;
    logic [15:0] e, x;
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    for (int i = 0; i < 3; i++) begin
      exact_p[i] = '0;
      approx_p[i] = '0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready[0]), 0);
    chk("rst_busy_done", 32'(busy[0]) | 32'(done[0]), 0);
    chk("rst_results", 32'(sample_cnt[0]) | 32'(err_cnt[0]) | 32'(max_ed[0]) | sum_ed[0], 0);
    in_valid[0] = 1'b1;
    #19 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_accept", 32'(sample_cnt[0]), 0);
    chk("idle_busy", 32'(busy[0]) | 32'(in_ready[0]), 0);
    in_valid[0] = 1'b0;

    // back-to-back directed run with a start pulse mid-run
    begin_run(0);
    push(0, 100, 100);
    start[0] = 1'b1;
    push(0, 200, 198);
    start[0] = 1'b0;
    push(0, 50, 60);
    push(0, 65535, 0);
    finish(0);
    chk("sum_ref", sum_ed[0], 65547);
    pdc = dc[0];
    exact_p[0] = 16'd9;
    approx_p[0] = 16'd1;
    in_valid[0] = 1'b1;
    repeat (3) @(negedge clk);
    in_valid[0] = 1'b0;
    chk("fifth_ignored", 32'(sample_cnt[0]), 4);
    chk("no_extra_done", dc[0], pdc);

    // stalled acceptance pattern
    begin_run(0);
    exact_p[0] = 16'd7;
    approx_p[0] = 16'd5;
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      in_valid[0] = pat[i];
      if (pat[i]) begin
        ev.push_back(16'd7);
        av.push_back(16'd5);
        cnt++;
      end
      @(negedge clk);
      chk("stall_cnt", 32'(sample_cnt[0]), cnt);
    end
    in_valid[0] = 1'b1;
    finish(0);
    in_valid[0] = 1'b0;
    chk("stall_total", 32'(sample_cnt[0]), 4);

    // asynchronous reset mid-run
    begin_run(0);
    push(0, 16'd1000, 16'd3);
    push(0, 16'd5, 16'd900);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_rst", 32'(sample_cnt[0]) | 32'(err_cnt[0]) | 32'(max_ed[0]) | sum_ed[0], 0);
    chk("midrun_rst_ctl", 32'(busy[0]) | 32'(in_ready[0]) | 32'(done[0]), 0);
    pdc = dc[0];
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_done", dc[0], pdc);
    chk("rst_stay_idle", 32'(busy[0]), 0);
    begin_run(0);
    for (int i = 0; i < 4; i++) push(0, 16'($urandom), 16'($urandom));
    finish(0);

    // single-sample run
    begin_run(1);
    push(1, 16'd300, 16'd299);
    finish(1);

    // randomised exact vs approximate products with random gaps
    begin_run(2);
    for (int i = 0; i < 256; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      e = 16'(a * b);
      x = e;
      if ($urandom_range(0, 3) == 0) x = e ^ 16'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) x = e & 16'hff00;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      push(2, e, x);
    end
    finish(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dadda_err_meter.md
DADDA_ERR_METER -- requirements
Module: dadda_err_meter

Interface
REQ-001 Parameter N_SAMPLES, default 256: number of product pairs per measurement run; legal range 1..65535.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port start  input  1  run request; sampled only in IDLE.
REQ-005 Port in_valid  input  1  exact_p/approx_p pair valid this cycle.
REQ-006 Port in_ready  output  1  block accepts a pair this cycle.
REQ-007 Port exact_p  input  16  exact 8x8 product, unsigned.
REQ-008 Port approx_p  input  16  approximate 8x8 Dadda product, unsigned.
REQ-009 Port busy  output  1  high in RUN and DRAIN.
REQ-010 Port done  output  1  one-cycle pulse when results are final.
REQ-011 Port sample_cnt  output  16  pairs accepted in the current or last run.
REQ-012 Port err_cnt  output  16  accepted pairs with exact_p != approx_p.
REQ-013 Port max_ed  output  16  largest error distance in the run.
REQ-014 Port sum_ed  output  32  sum of error distances in the run.

Function
REQ-015 Error distance ED SHALL be |exact_p - approx_p|, unsigned, 16 bits, computed without wrap (larger minus smaller).
REQ-016 FSM states SHALL be IDLE, RUN, DRAIN, DONE; encoding is free.
REQ-017 IDLE: in_ready=0, busy=0; start=1 -> RUN next cycle; sample_cnt, err_cnt, max_ed, sum_ed cleared to 0 on that same edge.
REQ-018 RUN: in_ready=1; a pair is accepted on every edge where in_valid=1 and in_ready=1; in_valid=0 stalls indefinitely with no state change.
REQ-019 Pipeline: stage 1 registers ED and a nonzero flag on acceptance; stage 2 updates err_cnt, max_ed, sum_ed one cycle later.
REQ-020 sample_cnt SHALL increment on the acceptance edge itself.
REQ-021 When the N_SAMPLES-th pair is accepted, RUN -> DRAIN; in_ready SHALL be 0 from the next cycle, so no pair beyond N_SAMPLES is ever accepted.
REQ-022 DRAIN SHALL last exactly one cycle (stage-2 update of last pair), then -> DONE.
REQ-023 DONE: done=1 for exactly one cycle, in_ready=0, busy=0; -> IDLE next cycle.
REQ-024 Latency: done SHALL assert exactly 2 cycles after the edge accepting the final pair.
REQ-025 max_ed SHALL update only if the new ED is strictly greater; ties leave it unchanged.
REQ-026 sum_ed cannot overflow (65535 x 65535 < 2^32); no saturation logic.
REQ-027 start in RUN, DRAIN or DONE SHALL be ignored; start held high in IDLE begins a new run on the first IDLE cycle, including the cycle after DONE.
REQ-028 Results SHALL hold stable from done until the edge that starts the next run.
REQ-029 N_SAMPLES=1: a single accept -> DRAIN -> DONE, same 2-cycle latency.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, in_ready=0, busy=0, done=0, and all result outputs and pipeline registers to 0, regardless of state.
REQ-031 Reset mid-RUN or mid-DRAIN discards the partial run; no done pulse is generated for it.
REQ-032 After rst_n deasserts, the block SHALL stay in IDLE until start is seen.

Verification
REQ-033 N_SAMPLES=4, start, feed pairs (100,100),(200,198),(50,60),(65535,0) back-to-back -> done 2 cycles after the 4th accept; sample_cnt=4, err_cnt=3, max_ed=65535, sum_ed=65547.
REQ-034 N_SAMPLES=4, in_valid toggled 1,0,0,1,1,0,1 with pairs all (7,5) -> exactly 4 accepts, in_ready=0 after the 4th; err_cnt=4, max_ed=2, sum_ed=8.
REQ-035 Pulse start during RUN, then feed a 5th valid pair after completion -> ignored; sample_cnt stays 4, single done pulse.
REQ-036 Assert rst_n=0 after 2 of 4 accepts -> all outputs 0 asynchronously, no done; fresh run gives correct totals.
REQ-037 N_SAMPLES=1, pair (300,299) -> done 2 cycles after accept, err_cnt=1, max_ed=1, sum_ed=1.
REQ-038 Randomised 256-pair run against exact vs approximate multiplier outputs -> all four results match a scoreboard.
